// File: rtl/pll_bringup_seq_if.sv
// Interface bundle for pll_bringup_seq.
// It carries the register front-end handshake (start/stop, configuration, status)
// and the PLL control and status pins.
// The slave modport is the sequencer side. The master modport is the front-end/PLL side.
interface pll_bringup_seq_if;
   logic       i_start;
   logic       i_stop;
   logic [7:0] i_mul;
   logic [7:0] i_div;
   logic       i_bypass;
   logic       pll_locked;
   logic       pll_error;
   logic       pll_enable;
   logic       pll_reset;
   logic       pll_bypass;
   logic [7:0] pll_mul;
   logic [7:0] pll_div;
   logic       soc_clk_select;
   logic       o_busy;
   logic       o_running;
   logic       o_fail;
   logic       o_cfg_err;
   logic [3:0] o_retry_cnt;

   modport slave (
      input  i_start, i_stop, i_mul, i_div, i_bypass, pll_locked, pll_error,
      output pll_enable, pll_reset, pll_bypass, pll_mul, pll_div, soc_clk_select,
             o_busy, o_running, o_fail, o_cfg_err, o_retry_cnt
   );

   modport master (
      output i_start, i_stop, i_mul, i_div, i_bypass, pll_locked, pll_error,
      input  pll_enable, pll_reset, pll_bypass, pll_mul, pll_div, soc_clk_select,
             o_busy, o_running, o_fail, o_cfg_err, o_retry_cnt
   );
endinterface

// File: rtl/pll_bringup_seq.sv
// PLL bring-up sequencer on the crystal clock.
// It resets and enables the PLL, qualifies lock with timeouts and retries,
// and then hands the SoC over to pll_clk. It falls back to xo_clk on lock loss or stop.
// Every output is taken straight from a flop.
module pll_bringup_seq #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 1024,
   parameter int STABLE_CYCLES = 64,
   parameter int MAX_RETRIES   = 3,
   parameter int DESEL_CYCLES  = 8
) (
   input  logic              xo_clk,
   input  logic              reset_n,
   pll_bringup_seq_if.slave  bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RST    = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_STABLE = 3'd3;
   localparam logic [2:0] S_RETRY  = 3'd4;
   localparam logic [2:0] S_RUN    = 3'd5;
   localparam logic [2:0] S_DESEL  = 3'd6;
   localparam logic [2:0] S_FAIL   = 3'd7;

   localparam logic [15:0] RST_LIM    = 16'(RST_CYCLES);
   localparam logic [15:0] LOCK_LIM   = 16'(LOCK_TIMEOUT);
   localparam logic [15:0] STABLE_LIM = 16'(STABLE_CYCLES);
   localparam logic [15:0] DESEL_LIM  = 16'(DESEL_CYCLES);
   localparam logic [3:0]  RETRY_LIM  = 4'(MAX_RETRIES);

   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]  lk_sync_q, lk_sync_d, er_sync_q, er_sync_d;
   logic [7:0]  mul_q, mul_d, div_q, div_d;
   logic        byp_q, byp_d;
   logic [3:0]  retry_q, retry_d;
   logic        cfg_err_q, cfg_err_d;
   logic        en_q, en_d, rst_q, rst_d, sel_q, sel_d;
   logic        busy_q, busy_d, running_q, running_d, fail_q, fail_d;
   logic        lk_s, er_s;

   assign lk_s = lk_sync_q[1];
   assign er_s = er_sync_q[1];

   // Next-state, counter, latch and synchronizer logic.
   always_comb begin
      state_d   = state_q;
      cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      cnt_d     = cnt_inc;
      lk_sync_d = {lk_sync_q[0], bus.pll_locked};
      er_sync_d = {er_sync_q[0], bus.pll_error};
      mul_d     = mul_q;
      div_d     = div_q;
      byp_d     = byp_q;
      retry_d   = retry_q;
      cfg_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_start && !bus.i_stop) begin
               if (bus.i_mul == 8'd0 || bus.i_div == 8'd0) begin
                  cfg_err_d = 1'b1;
               end else begin
                  mul_d   = bus.i_mul;
                  div_d   = bus.i_div;
                  byp_d   = bus.i_bypass;
                  retry_d = 4'd0;
                  state_d = S_RST;
               end
            end
         end
         S_RST: begin
            if (bus.i_stop)              state_d = S_IDLE;
            else if (cnt_inc >= RST_LIM) state_d = byp_q ? S_RUN : S_WAIT;
         end
         S_WAIT: begin
            if (bus.i_stop)                        state_d = S_IDLE;
            else if (lk_s)                         state_d = S_STABLE;
            else if (er_s || cnt_inc >= LOCK_LIM)  state_d = S_RETRY;
         end
         S_STABLE: begin
            if (bus.i_stop)                  state_d = S_IDLE;
            else if (!lk_s || er_s)          state_d = S_RETRY;
            else if (cnt_inc >= STABLE_LIM)  state_d = S_RUN;
         end
         S_RETRY: begin
            if (bus.i_stop) begin
               state_d = S_IDLE;
            end else if (retry_q < RETRY_LIM) begin
               retry_d = retry_q + 4'd1;
               state_d = S_RST;
            end else begin
               state_d = S_FAIL;
            end
         end
         S_RUN: begin
            if (bus.i_stop)                         state_d = S_DESEL;
            else if (!byp_q && (!lk_s || er_s))     state_d = S_RETRY;
         end
         S_DESEL: begin
            if (cnt_inc >= DESEL_LIM) state_d = S_IDLE;
         end
         S_FAIL: begin
            if (bus.i_stop) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_RUN && state_q != S_RUN) retry_d = 4'd0;
      if (state_d != state_q) cnt_d = 16'd0;
   end

   // Output values for the state being entered, so each output is a plain flop.
   // RETRY keeps pll_reset low for one more cycle.
   // This keeps pll_clk running while the glitch-free mux finishes switching away.
   always_comb begin
      en_d      = !(state_d == S_IDLE || state_d == S_FAIL);
      rst_d     = (state_d == S_IDLE || state_d == S_RST || state_d == S_FAIL);
      sel_d     = (state_d == S_RUN);
      busy_d    = !(state_d == S_IDLE || state_d == S_RUN || state_d == S_FAIL);
      running_d = (state_d == S_RUN);
      fail_d    = (state_d == S_FAIL);
   end

   // State, counters, latches and registered outputs.
   // An asynchronous reset forces the safe xo_clk configuration.
   always_ff @(posedge xo_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         lk_sync_q <= 2'b00;
         er_sync_q <= 2'b00;
         mul_q     <= 8'd1;
         div_q     <= 8'd1;
         byp_q     <= 1'b0;
         retry_q   <= 4'd0;
         cfg_err_q <= 1'b0;
         en_q      <= 1'b0;
         rst_q     <= 1'b1;
         sel_q     <= 1'b0;
         busy_q    <= 1'b0;
         running_q <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lk_sync_q <= lk_sync_d;
         er_sync_q <= er_sync_d;
         mul_q     <= mul_d;
         div_q     <= div_d;
         byp_q     <= byp_d;
         retry_q   <= retry_d;
         cfg_err_q <= cfg_err_d;
         en_q      <= en_d;
         rst_q     <= rst_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         running_q <= running_d;
         fail_q    <= fail_d;
      end
   end

   assign bus.pll_enable     = en_q;
   assign bus.pll_reset      = rst_q;
   assign bus.pll_bypass     = byp_q;
   assign bus.pll_mul        = mul_q;
   assign bus.pll_div        = div_q;
   assign bus.soc_clk_select = sel_q;
   assign bus.o_busy         = busy_q;
   assign bus.o_running      = running_q;
   assign bus.o_fail         = fail_q;
   assign bus.o_cfg_err      = cfg_err_q;
   assign bus.o_retry_cnt    = retry_q;

endmodule

// File: tb/tb_pll_bringup_seq.sv
// Scoreboard bench for pll_bringup_seq.
// Each stimulus step queues the output values expected at a given future cycle.
// The values are checked on the falling edge of that cycle.
module tb_pll_bringup_seq;
   localparam int RC = 4, LT = 20, SC = 8, MR = 2, DC = 3;
   localparam int P_SEL = 0, P_EN = 1, P_RST = 2, P_BYP = 3, P_MUL = 4, P_DIV = 5;
   localparam int P_RUN = 6, P_FAIL = 7, P_BUSY = 8, P_CFG = 9, P_RTY = 10;

   logic xo_clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 xo_clk = ~xo_clk;

   pll_bringup_seq_if bus();

   pll_bringup_seq #(
      .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
      .MAX_RETRIES(MR), .DESEL_CYCLES(DC)
   ) dut (
      .xo_clk (xo_clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   int cyc = 0;
   always @(posedge xo_clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      int          id;
      logic [31:0] exp;
      string       tag;
   } sb_t;
   sb_t sbq[$];

   int n_vec = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] probe(input int id);
      case (id)
         P_SEL:   return {31'd0, bus.soc_clk_select};
         P_EN:    return {31'd0, bus.pll_enable};
         P_RST:   return {31'd0, bus.pll_reset};
         P_BYP:   return {31'd0, bus.pll_bypass};
         P_MUL:   return {24'd0, bus.pll_mul};
         P_DIV:   return {24'd0, bus.pll_div};
         P_RUN:   return {31'd0, bus.o_running};
         P_FAIL:  return {31'd0, bus.o_fail};
         P_BUSY:  return {31'd0, bus.o_busy};
         P_CFG:   return {31'd0, bus.o_cfg_err};
         P_RTY:   return {28'd0, bus.o_retry_cnt};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic expect_at(input int dly, input int id, input logic [31:0] v, input string tag);
      sb_t e;
      e.due = cyc + dly;
      e.id  = id;
      e.exp = v;
      e.tag = tag;
      sbq.push_back(e);
   endtask

   task automatic sb_drain();
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].due <= cyc) begin
            chk(sbq[i].tag, probe(sbq[i].id), sbq[i].exp);
            sbq.delete(i);
         end
      end
   endtask

   task automatic tick();
      @(negedge xo_clk);
      sb_drain();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic start_cmd(input logic [7:0] m, input logic [7:0] d, input logic byp);
      bus.i_start  = 1'b1;
      bus.i_mul    = m;
      bus.i_div    = d;
      bus.i_bypass = byp;
   endtask

   task automatic expect_reset_values(input int dly, input string ctx);
      expect_at(dly, P_EN,   0, {ctx, "_en"});
      expect_at(dly, P_RST,  1, {ctx, "_rst"});
      expect_at(dly, P_BYP,  0, {ctx, "_byp"});
      expect_at(dly, P_MUL,  1, {ctx, "_mul"});
      expect_at(dly, P_DIV,  1, {ctx, "_div"});
      expect_at(dly, P_SEL,  0, {ctx, "_sel"});
      expect_at(dly, P_BUSY, 0, {ctx, "_busy"});
      expect_at(dly, P_RUN,  0, {ctx, "_run"});
      expect_at(dly, P_FAIL, 0, {ctx, "_fail"});
      expect_at(dly, P_CFG,  0, {ctx, "_cfg"});
      expect_at(dly, P_RTY,  0, {ctx, "_rty"});
   endtask

   initial begin
      bus.i_start    = 1'b0;
      bus.i_stop     = 1'b0;
      bus.i_mul      = 8'd0;
      bus.i_div      = 8'd0;
      bus.i_bypass   = 1'b0;
      bus.pll_locked = 1'b0;
      bus.pll_error  = 1'b0;
      run(2);
      expect_reset_values(0, "por");
      sb_drain();
      reset_n = 1'b1;
      tick();

      // Rejected starts: div=0, then mul=0, then start together with stop.
      start_cmd(8'd5, 8'd0, 1'b0);
      expect_at(1, P_CFG, 1, "cfg_div0_pulse");
      expect_at(1, P_BUSY, 0, "cfg_div0_idle");
      expect_at(1, P_DIV, 1, "cfg_div0_div");
      expect_at(2, P_CFG, 0, "cfg_div0_one_cycle");
      tick();
      bus.i_start = 1'b0;
      tick();
      start_cmd(8'd0, 8'd3, 1'b0);
      expect_at(1, P_CFG, 1, "cfg_mul0_pulse");
      expect_at(1, P_MUL, 1, "cfg_mul0_mul");
      tick();
      bus.i_start = 1'b0;
      tick();
      start_cmd(8'd7, 8'd3, 1'b0);
      bus.i_stop = 1'b1;
      expect_at(1, P_BUSY, 0, "startstop_idle");
      expect_at(1, P_CFG, 0, "startstop_nocfg");
      expect_at(1, P_MUL, 1, "startstop_mul");
      tick();
      bus.i_start = 1'b0;
      bus.i_stop  = 1'b0;
      tick();

      // Happy path: pll_reset held for RC cycles, lock 5 cycles after it falls.
      start_cmd(8'd10, 8'd2, 1'b0);
      expect_at(1, P_EN, 1, "hp_en_on");
      expect_at(1, P_RST, 1, "hp_rst_first");
      expect_at(RC, P_RST, 1, "hp_rst_last");
      expect_at(RC + 1, P_RST, 0, "hp_rst_fall");
      expect_at(RC + 1, P_MUL, 10, "hp_mul");
      expect_at(RC + 1, P_DIV, 2, "hp_div");
      tick();
      bus.i_start = 1'b0;
      run(RC + 5);
      bus.pll_locked = 1'b1;
      expect_at(3 + SC - 1, P_SEL, 0, "hp_sel_early");
      expect_at(3 + SC, P_SEL, 1, "hp_sel_rise");
      expect_at(3 + SC, P_RUN, 1, "hp_running");
      expect_at(3 + SC, P_BUSY, 0, "hp_not_busy");
      expect_at(3 + SC, P_RTY, 0, "hp_rty");
      run(3 + SC + 2);

      // Lock loss in RUN, then re-sequence and relock.
      bus.pll_locked = 1'b0;
      expect_at(2, P_SEL, 1, "loss_sel_hold");
      expect_at(3, P_SEL, 0, "loss_sel_drop");
      expect_at(4, P_RST, 1, "loss_rst_again");
      expect_at(4, P_EN, 1, "loss_en");
      expect_at(4, P_RTY, 1, "loss_rty");
      run(6);
      bus.pll_locked = 1'b1;
      expect_at(3 + SC - 1, P_SEL, 0, "relock_sel_early");
      expect_at(3 + SC, P_SEL, 1, "relock_sel");
      expect_at(3 + SC, P_RTY, 0, "relock_rty_clr");
      run(3 + SC + 2);

      // Stop from RUN: select drops next cycle, PLL disabled DC cycles later.
      bus.i_stop = 1'b1;
      expect_at(1, P_SEL, 0, "stop_sel");
      expect_at(1, P_BUSY, 1, "stop_desel_busy");
      expect_at(DC, P_EN, 1, "stop_en_hold");
      expect_at(DC + 1, P_EN, 0, "stop_en_off");
      expect_at(DC + 1, P_RST, 1, "stop_rst");
      expect_at(DC + 1, P_BUSY, 0, "stop_idle");
      tick();
      bus.i_stop = 1'b0;
      run(DC + 3);

      // Lock glitch at STABLE count 5, then a clean relock.
      bus.pll_locked = 1'b0;
      run(3);
      start_cmd(8'd10, 8'd2, 1'b0);
      tick();
      bus.i_start = 1'b0;
      run(RC);
      bus.pll_locked = 1'b1;
      run(6);
      bus.pll_locked = 1'b0;
      expect_at(2, P_RUN, 0, "gl_not_run");
      expect_at(3, P_EN, 1, "gl_retry_en");
      expect_at(4, P_RST, 1, "gl_rst_again");
      expect_at(4, P_RTY, 1, "gl_rty1");
      expect_at(RC + 4 + 1 + SC - 1, P_RUN, 0, "gl_run_early");
      expect_at(RC + 4 + 1 + SC, P_RUN, 1, "gl_run");
      expect_at(RC + 4 + 1 + SC, P_SEL, 1, "gl_sel");
      expect_at(RC + 4 + 1 + SC, P_RTY, 0, "gl_rty0");
      tick();
      bus.pll_locked = 1'b1;
      run(RC + 4 + SC + 2);
      bus.i_stop = 1'b1;
      expect_at(DC + 1, P_EN, 0, "gl_stop_en");
      tick();
      bus.i_stop = 1'b0;
      run(DC + 3);

      // Timeout on every attempt ending in FAIL, then stop back to IDLE.
      bus.pll_locked = 1'b0;
      run(3);
      start_cmd(8'd3, 8'd1, 1'b0);
      expect_at(RC + 1, P_RST, 0, "to_wait1");
      expect_at(RC + LT, P_RST, 0, "to_wait1_end");
      expect_at(RC + LT + 1, P_EN, 1, "to_retry1_en");
      expect_at(RC + LT + 2, P_RST, 1, "to_rst2");
      expect_at(RC + LT + 2, P_RTY, 1, "to_rty1");
      expect_at(2 * RC + LT + 2, P_RST, 0, "to_wait2");
      expect_at(2 * (RC + LT + 1) + 1, P_RTY, 2, "to_rty2");
      expect_at(3 * RC + 2 * LT + 3, P_RST, 0, "to_wait3");
      expect_at(3 * (RC + LT + 1), P_FAIL, 0, "to_not_fail_yet");
      expect_at(3 * (RC + LT + 1) + 1, P_FAIL, 1, "to_fail");
      expect_at(3 * (RC + LT + 1) + 1, P_EN, 0, "to_fail_en");
      expect_at(3 * (RC + LT + 1) + 1, P_RST, 1, "to_fail_rst");
      expect_at(3 * (RC + LT + 1) + 1, P_RTY, 2, "to_fail_rty");
      expect_at(3 * (RC + LT + 1) + 1, P_BUSY, 0, "to_fail_busy");
      expect_at(3 * (RC + LT + 1) + 1, P_SEL, 0, "to_fail_sel");
      tick();
      bus.i_start = 1'b0;
      run(3 * (RC + LT + 1) + 4);
      bus.i_stop = 1'b1;
      expect_at(1, P_FAIL, 0, "to_stop_fail");
      expect_at(1, P_BUSY, 0, "to_stop_idle");
      expect_at(1, P_EN, 0, "to_stop_en");
      tick();
      bus.i_stop = 1'b0;
      tick();

      // Bypass: RUN straight after RST, lock and error ignored, start ignored.
      start_cmd(8'd4, 8'd1, 1'b1);
      expect_at(RC, P_RUN, 0, "byp_rst_phase");
      expect_at(RC, P_RST, 1, "byp_rst_high");
      expect_at(RC + 1, P_RUN, 1, "byp_run");
      expect_at(RC + 1, P_SEL, 1, "byp_sel");
      expect_at(RC + 1, P_BYP, 1, "byp_pin");
      expect_at(RC + 1, P_RST, 0, "byp_rst_low");
      expect_at(RC + 1, P_EN, 1, "byp_en");
      tick();
      bus.i_start = 1'b0;
      bus.pll_error = 1'b1;
      expect_at(RC + 8, P_RUN, 1, "byp_err_ignored");
      expect_at(RC + 8, P_SEL, 1, "byp_sel_hold");
      run(RC + 8);
      start_cmd(8'd9, 8'd9, 1'b0);
      expect_at(1, P_MUL, 4, "byp_start_ignored");
      expect_at(1, P_RUN, 1, "byp_still_run");
      tick();
      bus.i_start = 1'b0;
      bus.pll_error = 1'b0;
      bus.i_stop = 1'b1;
      expect_at(DC + 1, P_EN, 0, "byp_stop_en");
      tick();
      bus.i_stop = 1'b0;
      run(DC + 3);

      // Asynchronous reset while in STABLE.
      bus.pll_locked = 1'b1;
      run(3);
      start_cmd(8'd6, 8'd3, 1'b0);
      expect_at(RC + 3, P_BUSY, 1, "ar_busy");
      expect_at(RC + 3, P_EN, 1, "ar_en");
      expect_at(RC + 3, P_RST, 0, "ar_rst_low");
      expect_at(RC + 3, P_MUL, 6, "ar_mul");
      tick();
      bus.i_start = 1'b0;
      run(RC + 2);
      #2;
      reset_n = 1'b0;
      #1;
      expect_reset_values(0, "ar");
      sb_drain();
      run(2);
      reset_n = 1'b1;
      run(2);

      if (sbq.size() != 0) chk("sb_left", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
